// File: rtl/conv_seq_ctrl.sv
// Convolution sequencing controller: loads a kernel bank, streams one frame of pixels
// to the convolution engine on request, then waits for the engine to finish.
// Optional macro CONV_SEQ_CYCLE_CNT_EN enables the saturating per-frame cycle counter.
module conv_seq_ctrl #(
  parameter int N   = 7,
  parameter int NOK = 6,
  parameter int KS  = 5,
  parameter int IMG = 224
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [N:0]                     ker_in,
  input  logic                           ker_in_valid,
  output logic                           ker_in_ready,
  input  logic [N:0]                     pix_in,
  input  logic                           pix_in_valid,
  output logic                           pix_in_ready,
  input  logic                           data_request,
  input  logic                           conv_fin,
  output logic [N:0]                     data,
  output logic                           data_valid,
  output logic [NOK*KS*KS*(N+1)-1:0]     ker,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    pix_cnt,
  output logic                           underflow,
  output logic [31:0]                    cycle_cnt
);

  localparam int          DW        = N + 1;
  localparam int          KW        = NOK * KS * KS;
  localparam int          KCW       = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [31:0] FRAME_PIX = 32'(IMG * IMG);

  typedef enum logic [2:0] {IDLE, LOAD_KER, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [KCW-1:0]   ker_cnt;
  logic             fin_seen;   // conv_fin seen while the last pixel was accepted

  logic start_frame, ker_acc, last_ker, last_pix;

  assign start_frame = (state == IDLE) && start;
  assign ker_acc     = (state == LOAD_KER) && ker_in_valid;
  assign last_ker    = ker_acc && (ker_cnt == KCW'(KW - 1));
  assign last_pix    = pix_in_ready && (pix_cnt == FRAME_PIX - 32'd1);

  assign ker_in_ready = (state == LOAD_KER);
  assign pix_in_ready = (state == RUN) && data_request && pix_in_valid && (pix_cnt < FRAME_PIX);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)                 state_nxt = LOAD_KER;
      LOAD_KER: if (last_ker)              state_nxt = RUN;
      RUN:      if (last_pix)              state_nxt = DRAIN;
      DRAIN:    if (conv_fin || fin_seen)  state_nxt = DONE;
      DONE:                                state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the kernel bank is a visible output that must read zero after reset, so it is
  // reset like ordinary flops instead of being left as an uninitialised memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ker_cnt    <= '0;
      ker        <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      pix_cnt    <= '0;
      underflow  <= 1'b0;
      fin_seen   <= 1'b0;
    end else begin
      if (start_frame) begin
        ker_cnt   <= '0;
        pix_cnt   <= '0;
        underflow <= 1'b0;
        fin_seen  <= 1'b0;
      end
      if (ker_acc) begin
        for (int w = 0; w < KW; w++) begin
          if (ker_cnt == KCW'(w)) ker[w*DW +: DW] <= ker_in;
        end
        ker_cnt <= ker_cnt + KCW'(1);
      end
      data_valid <= pix_in_ready;
      if (pix_in_ready) begin
        data    <= pix_in;
        pix_cnt <= pix_cnt + 32'd1;
      end
      if ((state == RUN) && data_request && !pix_in_valid) underflow <= 1'b1;
      if (last_pix) fin_seen <= conv_fin;
    end
  end

`ifdef CONV_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else if (start_frame) begin
      cyc_q <= '0;
    end else if (((state == LOAD_KER) || (state == RUN) || (state == DRAIN)) && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomised scoreboard bench for conv_seq_ctrl (NOK=2, KS=3, IMG=4): a driver predicts
// accepted pixels into a queue, and an independent monitor checks every data_valid beat.
module tb_conv_seq_ctrl;
  localparam int N     = 7;
  localparam int NOK   = 2;
  localparam int KS    = 3;
  localparam int IMG   = 4;
  localparam int DW    = N + 1;
  localparam int KW    = NOK * KS * KS;
  localparam int FRAME = IMG * IMG;
  localparam int KB    = KW * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [N:0]    ker_in = '0;
  logic          ker_in_valid = 1'b0;
  logic          ker_in_ready;
  logic [N:0]    pix_in = '0;
  logic          pix_in_valid = 1'b0;
  logic          pix_in_ready;
  logic          data_request = 1'b0;
  logic          conv_fin = 1'b0;
  logic [N:0]    data;
  logic          data_valid;
  logic [KB-1:0] ker;
  logic          busy;
  logic          done;
  logic [31:0]   pix_cnt;
  logic          underflow;
  logic [31:0]   cycle_cnt;

  conv_seq_ctrl #(.N(N), .NOK(NOK), .KS(KS), .IMG(IMG)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ker_in       (ker_in),
    .ker_in_valid (ker_in_valid),
    .ker_in_ready (ker_in_ready),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_in_ready (pix_in_ready),
    .data_request (data_request),
    .conv_fin     (conv_fin),
    .data         (data),
    .data_valid   (data_valid),
    .ker          (ker),
    .busy         (busy),
    .done         (done),
    .pix_cnt      (pix_cnt),
    .underflow    (underflow),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [N:0] exp_q[$];
  logic [N:0] ker_model [KW];
  bit         uf_model;
  int         cyc_model;
  int         pix_model;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered pixel must match the oldest predicted pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && data_valid !== 1'b0) begin
        if (exp_q.size() == 0) check("unexpected_data_valid", {255'd0, data_valid}, 256'd0);
        else                   check("data", {248'd0, data}, {248'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [KB-1:0] ker_flat();
    logic [KB-1:0] v;
    v = '0;
    for (int i = 0; i < KW; i++) v[i*DW +: DW] = ker_model[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_cycles();
`ifdef CONV_SEQ_CYCLE_CNT_EN
    return 32'(cyc_model);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc_model = 0;
    uf_model  = 1'b0;
    pix_model = 0;
    check("busy_after_start", {255'd0, busy}, 256'd1);
    check("pix_cnt_cleared", {224'd0, pix_cnt}, 256'd0);
    check("underflow_cleared", {255'd0, underflow}, 256'd0);
  endtask

  // Offer kernel words; random gaps, stray starts and pixel traffic must not disturb loading.
  task automatic load_kernels(input bit gaps, input bit seq);
    int i;
    int guard;
    bit v;
    logic [N:0] w;
    i = 0;
    guard = 0;
    while (i < KW && guard < 500) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      w = seq ? DW'(i + 1) : DW'($urandom);
      ker_in_valid = v;
      ker_in       = w;
      start        = ($urandom_range(0, 7) == 0);
      data_request = 1'($urandom);
      pix_in_valid = 1'($urandom);
      #1;
      if (i == 0) check("ker_in_ready_load", {255'd0, ker_in_ready}, 256'd1);
      if (v) begin
        ker_model[i] = w;
        i++;
      end
      tick();
      cyc_model++;
      guard++;
    end
    if (guard >= 500) check("load_timeout", 256'd1, 256'd0);
    ker_in_valid = 1'b0;
    start        = 1'b0;
    data_request = 1'b0;
    pix_in_valid = 1'b0;
  endtask

  // Deliver pixels until 'limit' have been accepted, predicting each accept from the handshake rule.
  task automatic run_pixels(input int limit, input bit always_on, input bit force_uf, input bit fin_at_last);
    int guard;
    bit dr, pv, rdy;
    guard = 0;
    while (pix_model < limit && guard < 1000) begin
      if (force_uf && guard < 2) begin
        dr = 1'b1;
        pv = 1'b0;
      end else begin
        dr = always_on ? 1'b1 : ($urandom_range(0, 3) != 0);
        pv = always_on ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      rdy = dr && pv;
      if (dr && !pv) uf_model = 1'b1;
      data_request = dr;
      pix_in_valid = pv;
      pix_in       = always_on ? DW'(pix_model) : DW'($urandom);
      ker_in_valid = 1'($urandom);
      ker_in       = DW'($urandom);
      start        = ($urandom_range(0, 7) == 0);
      conv_fin     = fin_at_last && rdy && (pix_model == FRAME - 1);
      #1;
      check("pix_in_ready", {255'd0, pix_in_ready}, {255'd0, rdy});
      if (rdy) begin
        exp_q.push_back(pix_in);
        pix_model++;
      end
      tick();
      cyc_model++;
      guard++;
      if (force_uf && guard == 2) begin
        check("underflow_set", {255'd0, underflow}, 256'd1);
        check("pix_cnt_held_on_underflow", {224'd0, pix_cnt}, 256'd0);
      end
    end
    if (guard >= 1000) check("run_timeout", 256'd1, 256'd0);
    start        = 1'b0;
    ker_in_valid = 1'b0;
    conv_fin     = 1'b0;
  endtask

  // Wait n cycles with conv_fin low, then one cycle with conv_fin=fin_last; DONE must follow.
  task automatic drain(input int n, input bit fin_last);
    for (int i = 0; i < n; i++) begin
      conv_fin     = 1'b0;
      data_request = 1'b1;
      pix_in_valid = 1'b1;
      #1;
      if (i == 0) begin
        check("no_ready_after_frame", {255'd0, pix_in_ready}, 256'd0);
        check("no_done_in_drain", {255'd0, done}, 256'd0);
      end
      tick();
      cyc_model++;
    end
    conv_fin = fin_last;
    tick();
    cyc_model++;
    conv_fin     = 1'b0;
    data_request = 1'b0;
    pix_in_valid = 1'b0;
    check("done_pulse", {255'd0, done}, 256'd1);
    check("busy_in_done", {255'd0, busy}, 256'd1);
    tick();
    check("done_cleared", {255'd0, done}, 256'd0);
    check("busy_cleared", {255'd0, busy}, 256'd0);
  endtask

  task automatic check_end();
    check("pix_cnt_final", {224'd0, pix_cnt}, 256'(FRAME));
    check("underflow_final", {255'd0, underflow}, {255'd0, uf_model});
    check("cycle_cnt_final", {224'd0, cycle_cnt}, {224'd0, exp_cycles()});
    check("ker_bank", {112'd0, ker}, {112'd0, ker_flat()});
    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, {255'd0, busy}, 256'd0);
    check({tag, "_done"}, {255'd0, done}, 256'd0);
    check({tag, "_data"}, {248'd0, data}, 256'd0);
    check({tag, "_data_valid"}, {255'd0, data_valid}, 256'd0);
    check({tag, "_pix_cnt"}, {224'd0, pix_cnt}, 256'd0);
    check({tag, "_underflow"}, {255'd0, underflow}, 256'd0);
    check({tag, "_cycle_cnt"}, {224'd0, cycle_cnt}, 256'd0);
    check({tag, "_ker"}, {112'd0, ker}, 256'd0);
  endtask

  initial begin
    #22;
    check_reset_state("reset");
    reset = 1'b1;

    // Frame 1: directed kernel 1..18 and pixels 0..15, conv_fin after 5 drain cycles.
    do_start();
    load_kernels(1'b0, 1'b1);
    check("ker_word0", {248'd0, ker[7:0]}, 256'd1);
    check("ker_word17", {248'd0, ker[KB-1 -: DW]}, 256'd18);
    run_pixels(FRAME, 1'b1, 1'b0, 1'b0);
    drain(5, 1'b1);
    check_end();
`ifdef CONV_SEQ_CYCLE_CNT_EN
    check("cycle_cnt_directed", {224'd0, cycle_cnt}, 256'd40);
`else
    check("cycle_cnt_directed", {224'd0, cycle_cnt}, 256'd0);
`endif

    // Frame 2: random traffic with a forced two-cycle underflow at the start of RUN.
    do_start();
    load_kernels(1'b1, 1'b0);
    run_pixels(FRAME, 1'b0, 1'b1, 1'b0);
    drain($urandom_range(0, 4), 1'b1);
    check_end();

    // Frame 3: conv_fin already high when the last pixel is accepted.
    do_start();
    load_kernels(1'b1, 1'b0);
    run_pixels(FRAME, 1'b0, 1'b0, 1'b1);
    drain(0, 1'b0);
    check_end();

    // Frame 4: asynchronous reset mid-RUN at pix_cnt=7.
    do_start();
    load_kernels(1'b0, 1'b0);
    run_pixels(7, 1'b0, 1'b0, 1'b0);
    check("pix_cnt_before_reset", {224'd0, pix_cnt}, 256'd7);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    exp_q.delete();
    data_request = 1'b0;
    pix_in_valid = 1'b0;
    #2;
    reset = 1'b1;

    // Frame 5: kernels reload cleanly after the reset.
    do_start();
    load_kernels(1'b1, 1'b0);
    run_pixels(FRAME, 1'b0, 1'b0, 1'b0);
    drain(2, 1'b1);
    check_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
